data_sram_responder: RTL
========================

// Module: data_sram_responder
// PURPOSE
//  Responder end of the CPU data SRAM interface: the memory side that the execute stage drives.
//  Accepts en/wen/addr/wdata each cycle and applies byte-masked writes to a word-organised RAM.
//  Returns read data after a fixed, parameterised latency through a read pipeline.
//  Used as the data memory model in the CPU verification top and as the basis of the FPGA data RAM.
// PARAMETERS
//  ADDR_W      16  word-address bits; RAM depth = 2**ADDR_W words of 32 bits
//  RD_LAT      1   read latency in cycles, legal 1..4 (1 = classic synchronous SRAM)
//  ERR_STICKY  1   1: addr_err holds until reset; 0: addr_err pulses for one cycle per bad access
// PORTS
//  clk              in   1   system clock, all logic on rising edge
//  resetn           in   1   asynchronous active-low reset
//  data_sram_en     in   1   access enable; no read or write when 0
//  data_sram_wen    in   4   byte write enables, bit i -> wdata[8i+7:8i]; 4'h0 = read
//  data_sram_addr   in   32  byte address; word index = addr[ADDR_W+1:2]
//  data_sram_wdata  in   32  write data
//  data_sram_rdata  out  32  read data, RD_LAT cycles after the read request
//  rdata_valid      out  1   one-cycle strobe marking the cycle data_sram_rdata is updated
//  addr_err         out  1   access with addr[1:0]!=0 or addr[31:ADDR_W+2]!=0 (see ERR_STICKY)
//  wr_count         out  32  number of accepted write cycles (en && wen!=0), wraps at 2**32
// BEHAVIOUR
//  Reset (resetn=0, asynchronous): rdata=0, rdata_valid=0, addr_err=0, wr_count=0, pipeline cleared.
//    RAM array is NOT reset; contents survive reset.
//  Write: en=1 && wen!=0 at edge k -> only the enabled bytes of word[idx] are updated at edge k.
//    Disabled bytes are unchanged. wen!=0 with en=0 -> no write and no count.
//  Read: en=1 && wen==0 at edge k -> word[idx] sampled at edge k.
//    Value appears on rdata after edge k+RD_LAT-1 and is valid for cycle k+RD_LAT.
//    rdata_valid=1 in exactly that cycle.
//  Write cycles also launch a read of the same word. rdata_valid is asserted for any en=1 access.
//    This matches the lab SRAM, where rdata always follows en.
//  Read-during-write to the same word in the same cycle: READ_FIRST; returns the pre-write data.
//  Back-to-back requests: one accepted every cycle; the pipeline is fully pipelined with no stall.
//  rdata holds its last value when no read completes; it is never cleared except by reset.
//  Out-of-range address: high bits are ignored, so the access aliases to word[idx].
//    The access still proceeds, and addr_err is asserted the cycle after the request.
//  Misaligned address: addr[1:0] is ignored for the access, and addr_err is asserted.
//  en=0: no state change except the pipeline advancing. rdata_valid=0 for that slot.
//  Reset mid-operation: in-flight reads are discarded. No rdata_valid follows the reset release.
//  wr_count: increments by 1 per accepted write cycle; 32'hFFFF_FFFF + 1 -> 0.
// STRUCTURE
//  Shared header: SRAM bus width constants and the RD_LAT legal range.
//  Header check: RD_LAT outside 1..4 -> elaboration error via generate.
//  Sub-module sram_rd_pipe: (RD_LAT-1)-deep shift of {valid, data} with async reset.
//  Top: RAM array, byte-lane write, first read register, error and counter logic.
// TESTING
//  1 Reset, then write 32'h1234_5678 at addr 0x10 with wen=4'hF, then read 0x10
//      -> rdata=32'h1234_5678 with rdata_valid exactly RD_LAT cycles after the read.
//  2 Partial write of wdata=32'hAABB_CCDD to 0x10 with wen=4'b0101 over old 32'h1234_5678
//      -> read returns 32'h12BB_56DD; wr_count=2.
//  3 In one cycle, write 32'hDEAD_BEEF to 0x20 (old value 0) and read it
//      -> that slot returns 0; the next read returns 32'hDEAD_BEEF.
//  4 Back-to-back reads of 0x0, 0x4, 0x8 holding 1, 2, 3 with RD_LAT=3
//      -> rdata 1, 2, 3 on consecutive cycles; rdata_valid high for 3 cycles.
//  5 Read 0x3, then read 0x8000_0010 with ADDR_W=16
//      -> addr_err=1; the second access returns word 4's data.
//      With ERR_STICKY=1, addr_err stays high until resetn=0.
//  6 Assert resetn=0 one cycle after a read with RD_LAT=2
//      -> rdata=0 and rdata_valid=0 immediately; no valid after release; RAM data intact.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// Shared SRAM bus constants, request/response structs and the read-latency legality check.
package data_sram_responder_pkg;
  localparam int SRAM_DW    = 32;
  localparam int SRAM_AW    = 32;
  localparam int SRAM_BW    = SRAM_DW / 8;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef struct packed {
    logic               en;
    logic [SRAM_BW-1:0] wen;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
  } sram_req_t;

  typedef struct packed {
    logic               vld;
    logic [SRAM_DW-1:0] data;
  } sram_rsp_t;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction
endpackage

// File: rtl/data_sram_responder_rd_pipe.sv
// Extra read-latency stages: shifts {valid, data}; data only advances with a valid slot so the
// output holds the last completed read.
module sram_rd_pipe
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      resetn,
  input  sram_rsp_t in_rsp,
  output sram_rsp_t out_rsp
);
  logic [DEPTH:1]              vld_pipe;
  logic [DEPTH:1][SRAM_DW-1:0] dat_pipe;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_rsp.vld;
      if (in_rsp.vld) dat_pipe[1] <= in_rsp.data;
      for (int s = 2; s <= DEPTH; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign out_rsp.vld  = vld_pipe[DEPTH];
  assign out_rsp.data = dat_pipe[DEPTH];
endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: byte-masked writes to a word RAM, READ_FIRST reads with RD_LAT latency,
// address-error flag and accepted-write counter.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int ERR_STICKY = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               data_sram_en,
  input  logic [SRAM_BW-1:0] data_sram_wen,
  input  logic [SRAM_AW-1:0] data_sram_addr,
  input  logic [SRAM_DW-1:0] data_sram_wdata,
  output logic [SRAM_DW-1:0] data_sram_rdata,
  output logic               rdata_valid,
  output logic               addr_err,
  output logic [31:0]        wr_count
);
  generate
    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
      $error("data_sram_responder: RD_LAT must be within 1..4");
    end
  endgenerate

  localparam int              WORDS   = 2 ** ADDR_W;
  // Address bits above the word index must be zero; none exist once the index spans the bus.
  localparam logic [SRAM_AW-1:0] HI_MASK =
    (ADDR_W >= SRAM_AW - 2) ? '0 : ~((32'h1 << (ADDR_W + 2)) - 32'h1);

  sram_req_t         req;
  logic [ADDR_W-1:0] idx;
  logic              wr_fire;
  logic              bad_addr;

  assign req      = '{en: data_sram_en, wen: data_sram_wen,
                      addr: data_sram_addr, wdata: data_sram_wdata};
  assign idx      = req.addr[ADDR_W+1:2];
  assign wr_fire  = req.en && (|req.wen);
  assign bad_addr = req.en && ((|req.addr[1:0]) || (|(req.addr & HI_MASK)));

  logic [SRAM_DW-1:0] mem [WORDS];

  // RAM is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < SRAM_BW; b++) begin
        if (req.wen[b]) mem[idx][8*b +: 8] <= req.wdata[8*b +: 8];
      end
    end
  end

  // First read register samples the pre-write word, giving READ_FIRST behaviour.
  sram_rsp_t rd0;
  sram_rsp_t rsp_out;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd0 <= '0;
    end else begin
      rd0.vld <= req.en;
      if (req.en) rd0.data <= mem[idx];
    end
  end

  generate
    if (RD_LAT <= 1) begin : g_lat1
      assign rsp_out = rd0;
    end else begin : g_latn
      sram_rd_pipe #(.DEPTH(RD_LAT - 1)) u_rd_pipe (
        .clk     (clk),
        .resetn  (resetn),
        .in_rsp  (rd0),
        .out_rsp (rsp_out)
      );
    end
  endgenerate

  assign data_sram_rdata = rsp_out.data;
  assign rdata_valid     = rsp_out.vld;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_err <= 1'b0;
      wr_count <= '0;
    end else begin
      addr_err <= (ERR_STICKY != 0) ? (addr_err | bad_addr) : bad_addr;
      if (wr_fire) wr_count <= wr_count + 32'd1;
    end
  end
endmodule
